regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port among N writeback requesters (ALU, load/store unit, mul/div). One grant per cycle under round-robin arbitration. The winning write is registered and driven onto the regfile write port (write / rd / rd_data) one cycle after acceptance. Optionally provides read-port bypass so the writes it holds are visible to same-cycle operand reads.

---
 rtl/regfile_wb_arbiter_if.sv | 28 ++
 rtl/regfile_wb_arbiter.sv | 63 ++++++
 tb/tb_regfile_wb_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: requester/regfile bundle for the writeback arbiter; WB_ARB_BYPASS_EN adds read-port forwarding signals
interface regfile_wb_arbiter_if #(parameter int N_REQ = 3);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0][4:0]  req_rd;
  logic [N_REQ-1:0][31:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   wr_en;
  logic [4:0]             wr_rd;
  logic [31:0]            wr_data;
  logic [15:0]            stall_cnt;
`ifdef WB_ARB_BYPASS_EN
  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic [31:0]            rf_rs1_data;
  logic [31:0]            rf_rs2_data;
  logic [31:0]            rs1_data;
  logic [31:0]            rs2_data;
  modport master (output req_valid, req_rd, req_data, rs1, rs2, rf_rs1_data, rf_rs2_data,
                  input req_ready, wr_en, wr_rd, wr_data, stall_cnt, rs1_data, rs2_data);
  modport slave  (input req_valid, req_rd, req_data, rs1, rs2, rf_rs1_data, rf_rs2_data,
                  output req_ready, wr_en, wr_rd, wr_data, stall_cnt, rs1_data, rs2_data);
`else
  modport master (output req_valid, req_rd, req_data,
                  input req_ready, wr_en, wr_rd, wr_data, stall_cnt);
  modport slave  (input req_valid, req_rd, req_data,
                  output req_ready, wr_en, wr_rd, wr_data, stall_cnt);
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the regfile write port; define WB_ARB_BYPASS_EN for combinational read-port forwarding
module regfile_wb_arbiter #(parameter int N_REQ = 3) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0]    r_ptr;
  logic             r_wr_en;
  logic [4:0]       r_wr_rd;
  logic [31:0]      r_wr_data;
  logic [15:0]      r_stall;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_next;
  logic             w_found;
  logic             w_lost;
  logic [N_REQ-1:0] w_ready;
  // first valid requester at or after r_ptr, wrapping, wins the port
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = int'(r_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_found && bus.req_valid[j]) begin
        w_found = 1'b1;
        w_gidx  = PW'(j);
      end
    end
    if (w_found) w_ready[w_gidx] = 1'b1;
  end
  assign w_next = (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
  assign w_lost = $countones(bus.req_valid) >= 2;
  // register the winning write; x0 targets are accepted but never enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
      r_stall   <= '0;
    end else begin
      r_wr_en <= w_found && (bus.req_rd[w_gidx] != 5'd0);
      if (w_found) begin
        r_wr_rd   <= bus.req_rd[w_gidx];
        r_wr_data <= bus.req_data[w_gidx];
        r_ptr     <= w_next;
      end
      if (w_lost && r_stall != 16'hFFFF) r_stall <= r_stall + 1'b1;
    end
  end
  assign bus.req_ready = w_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_rd     = r_wr_rd;
  assign bus.wr_data   = r_wr_data;
  assign bus.stall_cnt = r_stall;
`ifdef WB_ARB_BYPASS_EN
  assign bus.rs1_data = (bus.rs1 == 5'd0) ? 32'd0 : (r_wr_en && r_wr_rd == bus.rs1) ? r_wr_data : bus.rf_rs1_data;
  assign bus.rs2_data = (bus.rs2 == 5'd0) ? 32'd0 : (r_wr_en && r_wr_rd == bus.rs2) ? r_wr_data : bus.rf_rs2_data;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table vectors plus scoreboard of expected writes, and corner sequences
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if #(.N_REQ(3)) bus();
  regfile_wb_arbiter #(.N_REQ(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [2:0]        v;
    logic [2:0][4:0]   rd;
    logic [2:0][31:0]  d;
    logic [2:0]        er;
  } vec_t;
  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] d;
    logic [15:0] st;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_ptr;
  logic [4:0]  m_rd;
  logic [31:0] m_d;
  logic [15:0] m_st;
  vec_t tv[15];
  logic [2:0] vs[15] = '{3'b010, 3'b000, 3'b100, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                         3'b011, 3'b110, 3'b101, 3'b101, 3'b001, 3'b100};
  logic [2:0] es[15] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                         3'b001, 3'b010, 3'b100, 3'b001, 3'b001, 3'b100};
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_rd", 32'(bus.wr_rd), 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_stall", 32'(bus.stall_cnt), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    m_ptr = 0;
    m_rd = '0;
    m_d = '0;
    m_st = '0;
    q.delete();
  endtask
  task automatic cycle(input logic [2:0] v, input logic [2:0][4:0] rd, input logic [2:0][31:0] d, input logic [2:0] er);
    exp_t e;
    int g;
    bit f;
    bus.req_valid = v;
    bus.req_rd = rd;
    bus.req_data = d;
    #3;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    f = 1'b0;
    g = 0;
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (m_ptr + k) % 3;
      if (!f && v[j]) begin
        f = 1'b1;
        g = j;
      end
    end
    if (f) begin
      m_rd = rd[g];
      m_d = d[g];
      m_ptr = (g + 1) % 3;
    end
    if ($countones(v) >= 2 && m_st != 16'hFFFF) m_st++;
    e.en = f && (rd[g] != 5'd0);
    e.rd = m_rd;
    e.d = m_d;
    e.st = m_st;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("wr_en", 32'(bus.wr_en), 32'(e.en));
    chk("wr_rd", 32'(bus.wr_rd), 32'(e.rd));
    chk("wr_data", bus.wr_data, e.d);
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.st));
  endtask
  initial begin
    logic [2:0][4:0]  rd;
    logic [2:0][31:0] d;
    bus.req_rd = '0;
    bus.req_data = '0;
`ifdef WB_ARB_BYPASS_EN
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.rf_rs1_data = '0;
    bus.rf_rs2_data = '0;
`endif
    for (int i = 0; i < 15; i++) begin
      tv[i].v = vs[i];
      tv[i].er = es[i];
      tv[i].rd = {5'd12, 5'd11, 5'd10};
      tv[i].d = {32'hCCCC0000 + 32'(i), 32'hBBBB0000 + 32'(i), 32'hAAAA0000 + 32'(i)};
    end
    tv[0].rd[1] = 5'd5;
    tv[0].d[1] = 32'hDEADBEEF;
    tv[2].rd[2] = 5'd0;
    tv[2].d[2] = 32'h1234;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(tv[i].v, tv[i].rd, tv[i].d, tv[i].er);
      if (i == 8) chk("stall_fair", 32'(bus.stall_cnt), 6);
    end
    rd = {5'd0, 5'd0, 5'd7};
    d = {32'd0, 32'd0, 32'h77777777};
    bus.req_valid = 3'b001;
    bus.req_rd = rd;
    bus.req_data = d;
    @(posedge clk);
    #1;
    bus.req_valid = 3'b000;
    chk("mid_wr_en", 32'(bus.wr_en), 1);
    chk("mid_wr_rd", 32'(bus.wr_rd), 7);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(bus.wr_en), 0);
    chk("mid_rst_stall", 32'(bus.stall_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ptr = 0;
    m_rd = '0;
    m_d = '0;
    m_st = '0;
    q.delete();
    cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 3'b001);
    do_reset();
    bus.req_valid = 3'b011;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(bus.stall_cnt), 32'hFFFE);
    @(posedge clk);
    #1;
    chk("sat_ffff", 32'(bus.stall_cnt), 32'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
    bus.req_valid = 3'b000;
`ifdef WB_ARB_BYPASS_EN
    do_reset();
    cycle(3'b001, {5'd0, 5'd0, 5'd3}, {32'd0, 32'd0, 32'hA5A5A5A5}, 3'b001);
    bus.req_valid = 3'b000;
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd0;
    bus.rf_rs1_data = 32'h0;
    bus.rf_rs2_data = 32'h55555555;
    #1;
    chk("byp_rs1", bus.rs1_data, 32'hA5A5A5A5);
    chk("byp_rs2_x0", bus.rs2_data, 32'h0);
    bus.rs1 = 5'd4;
    bus.rf_rs1_data = 32'h77;
    bus.rs2 = 5'd3;
    #1;
    chk("byp_rs1_miss", bus.rs1_data, 32'h77);
    chk("byp_rs2_hit", bus.rs2_data, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    chk("byp_after", bus.rs2_data, 32'h55555555);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
